// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the IF/MEM memory port arbiter.
//   arb_state_t    : arbiter FSM state encoding
//   GNT_IF/GNT_MEM : encoding of which CPU port owns the access in flight
//   STARVE_MAX_DEF : default number of back-to-back MEM grants that may pass
//                    a waiting fetch before the fetch is forced through
//   is_busy()      : true while an access is outstanding on the memory side
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

    localparam int STARVE_MAX_DEF = 4;

    function automatic logic is_busy(input arb_state_t s);
        return (s == BUSY_IF) || (s == BUSY_MEM);
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// ----------------------------------------------------------------------------
// arb_starve_cnt
// Saturating count of consecutive MEM grants taken while a fetch was waiting.
// When the count reaches STARVE_MAX the next arbitration must go to IF.
//   clk, rst_n : clock, synchronous active-low reset
//   arb_en     : an arbitration (grant) happens this cycle
//   gnt_mem    : the grant in this cycle goes to MEM
//   if_pending : a fetch is waiting in this cycle
//   force_if   : count has reached STARVE_MAX, IF must win next time
// ----------------------------------------------------------------------------
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic gnt_mem,
    input  logic if_pending,
    output logic force_if
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (arb_en) begin
            if (gnt_mem && if_pending) begin
                if (cnt < CNT_MAX) begin
                    cnt <= cnt + 4'd1;
                end
            end else begin
                // IF grant, or a MEM grant with nobody waiting: streak is over
                cnt <= '0;
            end
        end
    end

    assign force_if = (cnt >= CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between the CPU fetch port (IF) and the
// load/store port (MEM). One access at a time; MEM normally wins, but a
// starvation counter forces IF through after STARVE_MAX MEM wins in a row.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | no access in flight; arbitrate and latch the m_* bus
//   BUSY_IF  | fetch access outstanding, m_req high until m_ack
//   BUSY_MEM | load/store access outstanding, m_req high until m_ack
//   DONE     | ready pulse to the granted port, back to IDLE next
//
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   if_req/if_addr          : fetch request, held until if_ready
//   if_ready/if_rdata       : fetch completion pulse and held fetch data
//   mem_rd/mem_wr/mem_addr/
//   mem_wdata               : load/store request, held until mem_ready
//   mem_ready/mem_rdata     : load/store completion pulse and held load data
//   stall_if/stall_mem      : port is requesting and not completing this cycle
//   m_req/m_we/m_addr/
//   m_wdata                 : registered memory request bus
//   m_ack/m_rdata           : memory completion and read data
//   proto_err               : sticky error (rd+wr together, or stray m_ack)
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,

    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_ready,
    output logic [DW-1:0] mem_rdata,

    output logic          stall_if,
    output logic          stall_mem,

    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,

    output logic          proto_err
);

    arb_state_t state;
    logic       gnt;

    logic mem_any;
    logic if_elig;
    logic mem_elig;
    logic arb_en;
    logic pick_mem;
    logic force_if;

    assign mem_any  = mem_rd | mem_wr;

    // A port whose ready is high this cycle has just been served and must
    // not be granted again on the same (still held) request.
    assign if_elig  = if_req  & ~if_ready;
    assign mem_elig = mem_any & ~mem_ready;

    assign arb_en   = (state == IDLE) && (if_elig || mem_elig);
    assign pick_mem = mem_elig && (!if_elig || !force_if);

    assign stall_if  = if_req  & ~if_ready;
    assign stall_mem = mem_any & ~mem_ready;

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .arb_en     (arb_en),
        .gnt_mem    (pick_mem),
        .if_pending (if_elig),
        .force_if   (force_if)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= GNT_IF;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;

            if (m_ack && !is_busy(state)) begin
                proto_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (arb_en) begin
                        m_req <= 1'b1;
                        if (pick_mem) begin
                            state   <= BUSY_MEM;
                            gnt     <= GNT_MEM;
                            // rd and wr together resolve to a write
                            m_we    <= mem_wr;
                            m_addr  <= mem_addr;
                            m_wdata <= mem_wdata;
                            if (mem_rd && mem_wr) begin
                                proto_err <= 1'b1;
                            end
                        end else begin
                            state  <= BUSY_IF;
                            gnt    <= GNT_IF;
                            m_we   <= 1'b0;
                            m_addr <= if_addr;
                        end
                    end
                end

                BUSY_IF, BUSY_MEM: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        state <= DONE;
                        if (gnt == GNT_IF) begin
                            if_rdata <= m_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            if (!m_we) begin
                                mem_rdata <= m_rdata;
                            end
                            mem_ready <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares one single-ported unified memory between the five-stage CPU's instruction-fetch port (IF) and data port (MEM, loads/stores). It serialises requests, holds the losing stage with a stall, and returns read data with a one-cycle ready pulse. It sits between the stage-1/stage-4 memory interfaces and the memory's req/ack handshake. A starvation counter keeps MEM priority from locking out fetch indefinitely.

## Interface
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive MEM grants with IF waiting before IF is forced; range 1..15
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  AW  fetch address
- if_ready  out  1  one-cycle completion pulse for IF
- if_rdata  out  DW  fetched word; valid with if_ready, held until next IF completion
- mem_rd / mem_wr  in  1  load / store request; held until mem_ready
- mem_addr  in  AW  data address
- mem_wdata  in  DW  store data
- mem_ready  out  1  one-cycle completion pulse for MEM
- mem_rdata  out  DW  load data; valid with mem_ready, held until next MEM completion
- stall_if  out  1  if_req & ~if_ready (combinational)
- stall_mem  out  1  (mem_rd|mem_wr) & ~mem_ready (combinational)
- m_req  out  1  memory request; held until m_ack
- m_we  out  1  write enable, stable while m_req
- m_addr  out  AW  registered address, stable while m_req
- m_wdata  out  DW  registered write data, stable while m_req
- m_ack  in  1  memory completion, one cycle, any latency ≥ 0 wait cycles after m_req rises
- m_rdata  in  DW  read data, valid with m_ack
- proto_err  out  1  sticky protocol error flag

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM, DONE.
- IDLE: arbitrate among eligible requests. A port is ineligible in the cycle its ready is high.
  - MEM only: go to BUSY_MEM.
  - IF only: go to BUSY_IF.
  - Both: MEM wins unless starve_cnt == STARVE_MAX, in which case IF wins.
  - Grant latches addr, we = mem_wr, and wdata into the m_* registers.
- BUSY_x: m_req = 1. On m_ack, capture m_rdata into the granted port's rdata register (reads only) and go to DONE.
- DONE: drive the granted port's ready = 1 for exactly one cycle, then return to IDLE. Arbitration occurs in the following IDLE cycle.
- Starvation counter starve_cnt (4 bits) is updated at each arbitration:
  - +1 on a MEM grant with if_req pending.
  - Cleared on an IF grant, or on any arbitration with if_req low.
  - Saturates at STARVE_MAX.
- mem_rd & mem_wr both high: perform a write, set proto_err.
- m_ack while not in BUSY_x: ignored, set proto_err.
- Write completion: mem_rdata unchanged; mem_ready still pulses.
- Requests dropped before ready: the access in flight still completes and its ready still pulses (the pipeline ignores it).
- Reset mid-access: FSM returns to IDLE and m_req drops on the next edge. The memory must tolerate abandoned requests.
- Reset values: all outputs 0 (if_rdata, mem_rdata, m_addr, m_wdata, starve_cnt, proto_err cleared; state IDLE).

## Timing
- Request high in IDLE at cycle 0: m_req high at cycle 1.
- Zero-wait m_ack at cycle 1: ready at cycle 2. Minimum latency is 2 cycles. With k wait cycles, latency is 2+k.
- Peak throughput is one access per 3 cycles (IDLE, BUSY, DONE).
- m_addr, m_we and m_wdata are registered and change only on the grant edge.
- if_ready and mem_ready are never high in the same cycle.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY_IF, BUSY_MEM, DONE);
  - grant encoding constants GNT_IF and GNT_MEM;
  - the default STARVE_MAX.
- One sub-module, arb_starve_cnt, contains the saturating counter and its force-IF output.

## Test plan
- IF only, addr 0x40, zero-wait memory returning 0x8C220010 → m_req at cycle 1, if_ready with if_rdata 0x8C220010 at cycle 2, stall_if high cycles 0–1.
- Simultaneous if_req (0x44) and mem_rd (0x100) → MEM granted first and mem_ready fires, then IF is granted; no overlapping m_req.
- mem_wr held continuously, if_req pending, STARVE_MAX=4 → exactly 4 MEM grants, then an IF grant; counter reads 0 afterwards.
- mem_wr to 0x20 with data 0xDEADBEEF, 3-wait memory → m_we/m_addr/m_wdata stable 4 cycles, mem_ready at cycle 5, mem_rdata unchanged.
- rst_n low during BUSY_MEM → next cycle state IDLE, m_req 0, all outputs 0; spurious m_ack afterwards sets proto_err only after reset is released.
- mem_rd and mem_wr both asserted → write performed, proto_err = 1 and remains set until reset.
